pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter WAIT_LIMIT, default 16, meaning the maximum number of FETCH cycles without imem_ack before timeout; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port stall, input, 1 bit: holds the sequencer out of FETCH while high.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-007 SHALL have port imem_addr, output, 32 bits: fetch address, always equal to pc.
REQ-008 SHALL have port imem_ack, input, 1 bit: memory returns instr_in this cycle.
REQ-009 SHALL have port instr_in, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port instr_out, output, 32 bits: registered instruction.
REQ-011 SHALL have port instr_valid, output, 1 bit: one-cycle pulse marking new instr_out.
REQ-012 SHALL have port exec_done, input, 1 bit: datapath finished the current instruction.
REQ-013 SHALL have port branch_taken, input, 1 bit: take alu_target, valid with exec_done.
REQ-014 SHALL have port alu_target, input, 32 bits: ALU-computed target, valid with exec_done.
REQ-015 SHALL have port pc, output, 32 bits: current program counter.
REQ-016 SHALL have port pc_plus4, output, 32 bits: combinational pc + 4, modulo 2^32.
REQ-017 SHALL have port sel_out, output, 1 bit: next-PC mux select; 0 selects the sequential sum, 1 selects the ALU target.
REQ-018 SHALL have port fetch_err, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-019 SHALL implement the states IDLE, FETCH and WAIT_EXEC.
REQ-020 IDLE SHALL move to FETCH when stall=0 and SHALL stay in IDLE when stall=1.
REQ-021 In FETCH, imem_req SHALL be 1; it SHALL be 0 in every other state.
REQ-022 FETCH with imem_ack=1 SHALL register instr_in into instr_out, pulse instr_valid in the following cycle, and go to WAIT_EXEC.
REQ-023 FETCH SHALL use an 8-bit wait counter, cleared on entry; when it reaches WAIT_LIMIT with no ack: set fetch_err, go to IDLE, pc unchanged (retry).
REQ-024 If imem_ack arrives in the same cycle the counter reaches WAIT_LIMIT, the ack SHALL win and no error SHALL be flagged.
REQ-025 stall SHALL NOT abort a FETCH in progress.
REQ-026 WAIT_EXEC SHALL ignore branch_taken and alu_target until exec_done=1.
REQ-027 On exec_done with branch_taken=1: pc <= {alu_target[31:2],2'b00}, sel_out <= 1.
REQ-028 On exec_done with branch_taken=0: pc <= pc+4 (wrapping FFFF_FFFC to 0000_0000), sel_out <= 0.
REQ-029 On exec_done, the next state SHALL be FETCH if stall=0, otherwise IDLE.
REQ-030 exec_done outside WAIT_EXEC SHALL be ignored.
REQ-031 Fetch latency SHALL be: imem_req asserted the first cycle in FETCH; instr_valid asserted 1 cycle after the ack.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, sel_out=0, instr_out=0, instr_valid=0, fetch_err=0, wait counter=0.
REQ-033 Reset SHALL override all other inputs, including reset asserted mid-FETCH with a simultaneous ack.

Configuration
REQ-034 With macro PC_SEQ_BRANCH_COUNT_EN defined: add output taken_count (32 bits), reset to 0, incremented on every exec_done with branch_taken=1 in WAIT_EXEC, wrapping at 2^32.
REQ-035 With PC_SEQ_BRANCH_COUNT_EN undefined: the taken_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset then release, stall=0, ack 2 cycles later with instr_in=32'h00A0_0093 -> imem_addr=0, instr_valid pulses once, instr_out=32'h00A0_0093.
REQ-037 exec_done with branch_taken=0 at pc=8 -> pc=12, sel_out=0; with branch_taken=1 and alu_target=32'h0000_0107 -> pc=32'h0000_0104, sel_out=1.
REQ-038 No ack for 16 FETCH cycles -> fetch_err=1, state IDLE, pc unchanged; a later ack clears nothing and fetch_err stays 1.
REQ-039 pc=32'hFFFF_FFFC with a not-taken exec_done -> pc=0; stall=1 at exec_done -> IDLE, imem_req stays 0 until stall drops.
REQ-040 rst_n=0 mid-FETCH with imem_ack=1 -> pc=RESET_PC, instr_valid=0; with PC_SEQ_BRANCH_COUNT_EN, 3 taken branches -> taken_count=3.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Instruction fetch sequencer. It fetches the word at pc, presents it as a
// registered instruction, waits for the datapath to finish it, and then
// advances pc either sequentially (pc + 4) or to an ALU-computed branch
// target. A fetch that sees no acknowledge for WAIT_LIMIT cycles is abandoned
// and retried from IDLE at the same pc; fetch_err records that this happened.
//
// Parameters
//   RESET_PC     pc value loaded at reset
//   WAIT_LIMIT   FETCH cycles without imem_ack before timeout (1..255)
//
// Optional feature
//   PC_SEQ_BRANCH_COUNT_EN  when defined, adds the taken_count output, which
//                           counts taken branches (wraps at 2^32)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   stall         keeps the sequencer out of FETCH while high
//   imem_req      instruction-memory request, high only in FETCH
//   imem_addr     fetch address (always equal to pc)
//   imem_ack      memory returns instr_in this cycle
//   instr_in      fetched instruction word
//   instr_out     registered instruction
//   instr_valid   one-cycle pulse marking a new instr_out
//   exec_done     datapath finished the current instruction
//   branch_taken  take alu_target (valid with exec_done)
//   alu_target    branch target (valid with exec_done)
//   pc            current program counter
//   pc_plus4      pc + 4, modulo 2^32
//   sel_out       next-pc select: 0 sequential, 1 ALU target
//   fetch_err     sticky fetch-timeout flag
//   taken_count   taken-branch count (PC_SEQ_BRANCH_COUNT_EN only)
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] instr_in,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] alu_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        sel_out,
   output logic        fetch_err
`ifdef PC_SEQ_BRANCH_COUNT_EN
   ,
   output logic [31:0] taken_count
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      WAIT_EXEC = 2'd2
   } state_t;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;    // FETCH cycles already spent without an ack
   logic       fetch_fire;  // ack accepted this cycle
   logic       timeout;     // fetch abandoned this cycle
   logic       exec_fire;   // instruction retired this cycle

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      fetch_fire = 1'b0;
      timeout    = 1'b0;
      exec_fire  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!stall) state_nxt = FETCH;
         end
         FETCH: begin
            // stall is deliberately not looked at: a fetch runs to ack or
            // timeout. The ack is tested first so it wins over a timeout
            // falling in the same cycle.
            imem_req = 1'b1;
            if (imem_ack) begin
               fetch_fire = 1'b1;
               state_nxt  = WAIT_EXEC;
            end else if (wait_cnt + 8'd1 == LIMIT) begin
               // this is the WAIT_LIMIT-th cycle in a row without an ack
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_EXEC: begin
            if (exec_done) begin
               exec_fire = 1'b1;
               state_nxt = stall ? IDLE : FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Counter is zero outside FETCH, so it is already clear on every entry.
   always_ff @(posedge clk) begin
      if (!rst_n)                                  wait_cnt <= 8'd0;
      else if (state == FETCH && state_nxt == FETCH) wait_cnt <= wait_cnt + 8'd1;
      else                                         wait_cnt <= 8'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         sel_out     <= 1'b0;
         instr_out   <= 32'd0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         instr_valid <= fetch_fire;
         if (fetch_fire) instr_out <= instr_in;
         if (timeout)    fetch_err <= 1'b1;
         if (exec_fire) begin
            // Branch targets are forced word-aligned.
            pc      <= branch_taken ? {alu_target[31:2], 2'b00} : pc_plus4;
            sel_out <= branch_taken;
         end
      end
   end

`ifdef PC_SEQ_BRANCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                        taken_count <= 32'd0;
      else if (exec_fire && branch_taken) taken_count <= taken_count + 32'd1;
   end
`endif

endmodule
